// File: rtl/pipe_add_sub.sv
// Pipelined add/subtract: STAGES ripple slices of W=WIDTH/STAGES bits, with operand skew and a stall-able valid pipe.
// Build option: define PIPE_ADD_SAT_EN to saturate the result on signed overflow.
module pipe_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             op_sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int W = WIDTH / STAGES;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe moves together; in_ready is the advance signal itself.
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = op_sub ? ~b : b;
    assign cin_eff  = op_sub ? 1'b1 : carry_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] a_sl;
        logic [W-1:0] b_sl;
        logic         c_src;
        logic         v_src;
        logic [W:0]   sl_sum;

        if (k == 0) begin : g_first
            assign a_sl  = a[W-1:0];
            assign b_sl  = b_eff[W-1:0];
            assign c_src = cin_eff;
            assign v_src = in_valid;
        end else begin : g_next
            assign a_sl  = g_stage[k-1].g_mid.a_q[W-1:0];
            assign b_sl  = g_stage[k-1].g_mid.b_q[W-1:0];
            assign c_src = g_stage[k-1].g_mid.c_q;
            assign v_src = g_stage[k-1].g_mid.v_q;
        end

        assign sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, c_src};

        if (k < STAGES - 1) begin : g_mid
            // Operand registers keep only the slices not yet added, rebased to bit 0.
            localparam int R = WIDTH - (k + 1) * W;
            logic                 v_q;
            logic                 c_q;
            logic [R-1:0]         a_q;
            logic [R-1:0]         b_q;
            logic [(k+1)*W-1:0]   s_q;
            logic [R-1:0]         a_rem;
            logic [R-1:0]         b_rem;
            logic [(k+1)*W-1:0]   s_new;

            if (k == 0) begin : g_src0
                assign a_rem = a[WIDTH-1:W];
                assign b_rem = b_eff[WIDTH-1:W];
                assign s_new = sl_sum[W-1:0];
            end else begin : g_srcn
                assign a_rem = g_stage[k-1].g_mid.a_q[R+W-1:W];
                assign b_rem = g_stage[k-1].g_mid.b_q[R+W-1:W];
                assign s_new = {sl_sum[W-1:0], g_stage[k-1].g_mid.s_q};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv) begin
                    v_q <= v_src;
                    c_q <= sl_sum[W];
                    a_q <= a_rem;
                    b_q <= b_rem;
                    s_q <= s_new;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] raw;
            logic [WIDTH-1:0] fin;
            logic             ovf;

            if (k == 0) begin : g_raw0
                assign raw = sl_sum[W-1:0];
            end else begin : g_rawn
                assign raw = {sl_sum[W-1:0], g_stage[k-1].g_mid.s_q};
            end

            // The top slice carries both operand sign bits, so overflow is decided here.
            assign ovf = (a_sl[W-1] == b_sl[W-1]) && (raw[WIDTH-1] != a_sl[W-1]);

`ifdef PIPE_ADD_SAT_EN
            assign fin = ovf ? {a_sl[W-1], {(WIDTH-1){~a_sl[W-1]}}} : raw;
`else
            assign fin = raw;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_src;
                    sum       <= fin;
                    carry_out <= sl_sum[W];
                    overflow  <= ovf;
                    zero      <= (fin == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed bench for pipe_add_sub (WIDTH=16, STAGES=4); results are packed as {sum, carry_out, overflow, zero}.
// Expected values follow the PIPE_ADD_SAT_EN build setting.
module tb_pipe_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        carry_in = 1'b0;
    logic        op_sub = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int consumed = 0;
    logic [18:0] exp_q[$];

`ifdef PIPE_ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    pipe_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .carry_in(carry_in), .op_sub(op_sub),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry_out(carry_out),
        .overflow(overflow), .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a result transfers on the next rising edge, so compare at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("result", {13'd0, sum, carry_out, overflow, zero}, {13'd0, exp_q.pop_front()});
            consumed++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs,
                        input logic [18:0] e, input bit push);
        int n;
        bit ok;
        a = va; b = vb; carry_in = vc; op_sub = vs; in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n <= 200) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
        if (ok && push) exp_q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    logic [15:0] dv_a[8], dv_b[8];
    logic        dv_c[8], dv_s[8];
    logic [18:0] dv_e[8];
    logic [15:0] bb_s[8];

    initial begin
        int n;
        int c0;
        int stray;

        // Directed table: {a, b, cin, sub} -> {sum, carry_out, overflow, zero}
        dv_a[0] = 16'hFFFF; dv_b[0] = 16'h0001; dv_c[0] = 0; dv_s[0] = 0; dv_e[0] = {16'h0000, 3'b101};
        dv_a[1] = 16'h7FFF; dv_b[1] = 16'h0001; dv_c[1] = 0; dv_s[1] = 0;
        dv_e[1] = SAT ? {16'h7FFF, 3'b010} : {16'h8000, 3'b010};
        dv_a[2] = 16'h0005; dv_b[2] = 16'h0007; dv_c[2] = 0; dv_s[2] = 1; dv_e[2] = {16'hFFFE, 3'b000};
        dv_a[3] = 16'h1234; dv_b[3] = 16'h4321; dv_c[3] = 1; dv_s[3] = 0; dv_e[3] = {16'h5556, 3'b000};
        dv_a[4] = 16'h8000; dv_b[4] = 16'h0001; dv_c[4] = 0; dv_s[4] = 1;
        dv_e[4] = SAT ? {16'h8000, 3'b110} : {16'h7FFF, 3'b110};
        dv_a[5] = 16'h8000; dv_b[5] = 16'h8000; dv_c[5] = 0; dv_s[5] = 0;
        dv_e[5] = SAT ? {16'h8000, 3'b110} : {16'h0000, 3'b111};
        dv_a[6] = 16'h1234; dv_b[6] = 16'h1234; dv_c[6] = 1; dv_s[6] = 1; dv_e[6] = {16'h0000, 3'b101};
        dv_a[7] = 16'h00FF; dv_b[7] = 16'h0001; dv_c[7] = 1; dv_s[7] = 0; dv_e[7] = {16'h0101, 3'b000};
        bb_s[0] = 16'h1112; bb_s[1] = 16'h2223; bb_s[2] = 16'h3334; bb_s[3] = 16'h4445;
        bb_s[4] = 16'h5556; bb_s[5] = 16'h6667; bb_s[6] = 16'h7778; bb_s[7] = 16'h8889;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single op latency: valid after the 3rd edge following the accept edge (cycle N+4)
        send(dv_a[0], dv_b[0], dv_c[0], dv_s[0], dv_e[0], 1'b1);
        wait_valid(n);
        check("latency_edges", 32'(n), 32'd3);
        drain("drain_single");

        // Directed vectors back-to-back, out_ready held high
        for (int i = 1; i < 8; i++) send(dv_a[i], dv_b[i], dv_c[i], dv_s[i], dv_e[i], 1'b1);
        drain("drain_vectors");

        // 8 back-to-back ops, downstream stalls from the 3rd result on
        c0 = consumed;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(16'(16'h1111 * i), 16'h0001, 1'b0, 1'b0, {bb_s[i-1], 3'b000}, 1'b1);
            end
            begin
                n = 0;
                while (consumed < c0 + 2 && n < 100) begin
                    tick();
                    n++;
                end
                out_ready = 1'b0;
                wait_valid(n);
                check("stall_sum_first", 32'(sum), 32'h3334);
                repeat (6) tick();
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_sum_held", 32'(sum), 32'h3334);
                check("stall_consumed", 32'(consumed - c0), 32'd2);
                out_ready = 1'b1;
            end
        join
        drain("drain_b2b");

        // Reset with three ops in flight (first one held at the output)
        out_ready = 1'b0;
        send(16'h8000, 16'h8000, 1'b0, 1'b0, '0, 1'b0);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, '0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_carry", 32'(carry_out), 32'd1);
        check("pre_rst_overflow", 32'(overflow), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_sum", 32'(sum), 32'd0);
        check("async_rst_carry", 32'(carry_out), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        check("async_rst_zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            stray += int'(out_valid);
        end
        check("no_stale_result", 32'(stray), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(dv_a[6], dv_b[6], dv_c[6], dv_s[6], dv_e[6], 1'b1);
        wait_valid(n);
        check("post_rst_latency", 32'(n), 32'd3);
        drain("drain_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
